sample_fifo: RTL
================

SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 16, bit width of one channel sample.
REQ-002 Parameter ADDR_WIDTH, default 3, log2 of depth; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter CHANNELS, default 1, number of sample lanes stored in lockstep per entry.
REQ-004 Parameter AFULL_THRESH, default DEPTH-2, almost_full asserts when fifo_count >= AFULL_THRESH.
REQ-005 Parameter AEMPTY_THRESH, default 2, almost_empty asserts when fifo_count <= AEMPTY_THRESH.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 reset_n  input  1  synchronous, active-low reset.
REQ-008 flush  input  1  synchronous clear of contents, active-high.
REQ-009 wr_valid  input  1  write request.
REQ-010 wr_ready  output  1  FIFO can accept a write.
REQ-011 wr_data  input  CHANNELS*DATA_WIDTH  write entry; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 rd_valid  output  1  rd_data holds a valid entry.
REQ-013 rd_ready  input  1  consumer takes rd_data.
REQ-014 rd_data  output  CHANNELS*DATA_WIDTH  head entry, same packing as wr_data.
REQ-015 fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 wr_ptr, rd_ptr  output  ADDR_WIDTH each  write/read addresses.
REQ-017 almost_full, almost_empty  output  1 each  threshold flags.
REQ-018 overflow  output  1  sticky: a write was attempted while full.

Function
REQ-019 Write accepted when wr_valid && wr_ready; wr_ready = (fifo_count != DEPTH).
REQ-020 Read accepted when rd_valid && rd_ready; rd_valid = (fifo_count != 0).
REQ-021 First-word-fall-through: rd_data shows entry at rd_ptr combinationally; a write into an empty FIFO appears on rd_data/rd_valid the cycle after acceptance (latency 1).
REQ-022 Accepted write stores wr_data at wr_ptr, wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
REQ-023 Accepted read increments rd_ptr modulo DEPTH.
REQ-024 fifo_count: +1 write only, -1 read only, unchanged for simultaneous accepted read and write or neither.
REQ-025 Simultaneous read+write when full: read accepted, write refused (wr_ready=0), count goes DEPTH-1.
REQ-026 Simultaneous read+write when empty: write accepted, read not (rd_valid=0), count goes 1.
REQ-027 wr_valid while full sets overflow=1 next cycle; data dropped; pointers/count unchanged.
REQ-028 rd_ready while empty has no effect.
REQ-029 flush=1: next cycle wr_ptr=rd_ptr=0, fifo_count=0; overrides any read/write that cycle; overflow unaffected.
REQ-030 almost_full/almost_empty combinational from fifo_count.
REQ-031 All lanes share pointers/count; no per-channel flow control.

Reset
REQ-032 reset_n=0 at a rising edge: wr_ptr=0, rd_ptr=0, fifo_count=0, overflow=0; hence wr_ready=1, rd_valid=0, almost_empty=1, almost_full=0.
REQ-033 Reset mid-operation discards all contents; storage array is not reset; rd_data undefined while rd_valid=0.
REQ-034 reset_n takes precedence over flush and all handshakes.

Configuration
REQ-035 Macro SAMPLE_FIFO_DROP_CNT_EN defined: extra output drop_count (16 bits) increments on each refused write (wr_valid && !wr_ready), saturates at 16'hFFFF, clears on reset_n=0 (not on flush).
REQ-036 Macro undefined: drop_count port and its logic absent; all other behaviour identical.

Structure
REQ-037 Package sample_fifo_pkg holds default parameter constants (DATA_WIDTH, ADDR_WIDTH, CHANNELS) and the drop_count width constant.
REQ-038 Storage in sub-module sample_fifo_mem: simple dual-port array, synchronous write, asynchronous read, no reset.

Verification
REQ-039 Reset, then 8 writes 16'h100..16'h107, rd_ready=0 -> fifo_count 8, wr_ready=0, almost_full=1 from count 6, wr_ptr=0.
REQ-040 Full, wr_valid=1 data 16'hDEAD one cycle -> overflow=1, count 8, DEAD never read; drop_count=1 when macro set.
REQ-041 Drain with rd_ready=1 -> rd_data 16'h100..16'h107 in order, rd_valid falls after 8 reads, almost_empty=1 at count 2.
REQ-042 Continuous write 16'h200.. with rd_ready=1 from empty -> count settles at 1, pointers wrap past 7 without loss, output order preserved.
REQ-043 CHANNELS=4, write {16'h4,16'h3,16'h2,16'h1} -> rd_data lane0=1, lane3=4 after one cycle.
REQ-044 Count 5, assert flush with simultaneous write -> next cycle count 0, pointers 0, rd_valid=0; reset_n=0 mid-traffic -> same plus overflow=0.

Source files
------------

// File: rtl/sample_fifo_pkg.sv
// Shared constants for the sample FIFO: default geometry and drop counter width.
package sample_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 3;
    localparam int unsigned DEF_CHANNELS   = 1;
    localparam int unsigned DROP_CNT_W     = 16;

endpackage : sample_fifo_pkg

// File: rtl/sample_fifo_if.sv
// Handshake, data and status bundle between a sample FIFO and its users.
interface sample_fifo_if
    import sample_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned CHANNELS   = DEF_CHANNELS
) ();

    localparam int unsigned ENTRY_W = CHANNELS * DATA_WIDTH;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;

    logic                  flush;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ENTRY_W-1:0]    wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ENTRY_W-1:0]    rd_data;
    logic [CNT_W-1:0]      fifo_count;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;

    // Producer/consumer side.
    modport master (
        output flush, wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, fifo_count, wr_ptr, rd_ptr,
               almost_full, almost_empty, overflow
    );

    // FIFO side.
    modport slave (
        input  flush, wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, fifo_count, wr_ptr, rd_ptr,
               almost_full, almost_empty, overflow
    );

endinterface : sample_fifo_if

// File: rtl/sample_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, not reset.
module sample_fifo_mem #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: store one entry on an accepted write.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : sample_fifo_mem

// File: rtl/sample_fifo.sv
// Multi-lane first-word-fall-through sample FIFO with threshold flags and sticky
// overflow. Define SAMPLE_FIFO_DROP_CNT_EN to add a saturating drop_count output.
module sample_fifo
    import sample_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int unsigned CHANNELS      = DEF_CHANNELS,
    parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sample_fifo_if.slave          bus
`ifdef SAMPLE_FIFO_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;
    localparam int unsigned ENTRY_W = CHANNELS * DATA_WIDTH;

    logic [CNT_W-1:0]      count_q,   count_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,  rd_ptr_d;
    logic                  overflow_q, overflow_d;

    logic full_c;
    logic empty_c;
    logic wr_en_c;
    logic rd_en_c;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == CNT_W'(0));
    // Flush overrides both handshakes in the same cycle.
    assign wr_en_c = bus.wr_valid && !full_c  && !bus.flush;
    assign rd_en_c = bus.rd_ready && !empty_c && !bus.flush;

    // Next-state for pointers, occupancy and sticky overflow.
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | (bus.wr_valid & full_c);

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_en_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({wr_en_c, rd_en_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    sample_fifo_mem #(
        .WIDTH      (ENTRY_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (bus.rd_data)
    );

    assign bus.wr_ready     = !full_c;
    assign bus.rd_valid     = !empty_c;
    assign bus.fifo_count   = count_q;
    assign bus.wr_ptr       = wr_ptr_q;
    assign bus.rd_ptr       = rd_ptr_q;
    assign bus.overflow     = overflow_q;
    assign bus.almost_full  = (count_q >= CNT_W'(AFULL_THRESH));
    assign bus.almost_empty = (count_q <= CNT_W'(AEMPTY_THRESH));

`ifdef SAMPLE_FIFO_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    // Count refused writes, holding at all-ones; flush does not clear it.
    always_comb begin
        drop_d = drop_q;
        if (bus.wr_valid && full_c && (drop_q != {DROP_CNT_W{1'b1}})) begin
            drop_d = drop_q + DROP_CNT_W'(1);
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule : sample_fifo
